// File: rtl/lsu_access_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | lsu_access_sequencer: MEM-stage load/store sequencer that splits          |
// | word-crossing accesses into two aligned memory cycles.  Rev 1.0           |
// +--------------------------------------------------------------------------+
module lsu_access_sequencer #(
   parameter int DM_ADDRESS = 9,
   parameter int DATA_W     = 32
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic                  req_store,
   input  logic [DM_ADDRESS-1:0] req_addr,
   input  logic [DATA_W-1:0]     req_wdata,
   input  logic [2:0]            req_funct3,
   output logic [DM_ADDRESS-1:0] mem_addr,
   output logic                  mem_re,
   output logic [3:0]            mem_be,
   output logic [DATA_W-1:0]     mem_wdata,
   input  logic [DATA_W-1:0]     mem_rdata,
   output logic                  rsp_valid,
   output logic [DATA_W-1:0]     rsp_rdata,
   output logic                  rsp_err
);
   localparam int WIDX = DM_ADDRESS - 2;

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_FIRST  = 2'd1,
      S_SECOND = 2'd2,
      S_RESP   = 2'd3
   } state_t;

   state_t                state_q, state_d;
   logic                  store_q, store_d;
   logic                  err_q, err_d;
   logic [DM_ADDRESS-1:0] addr_q, addr_d;
   logic [DATA_W-1:0]     wdata_q, wdata_d;
   logic [2:0]            funct3_q, funct3_d;
   logic [DATA_W-1:0]     word0_q, word0_d;
   logic [23:0]           word1_q, word1_d;

   logic                  req_legal;
   logic [1:0]            off;
   logic [3:0]            size;
   logic [7:0]            mask;
   logic                  crosses;
   logic [WIDX-1:0]       widx, widx_next;
   logic [2*DATA_W-1:0]   st_wide;
   logic [23:0]           w1;
   logic [DATA_W-1:0]     ld_word;
   logic [DATA_W-1:0]     ld_ext;

   assign req_legal = req_store ? (req_funct3 inside {3'b000, 3'b001, 3'b010})
                                : (req_funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});

   assign off       = addr_q[1:0];
   assign widx      = addr_q[DM_ADDRESS-1:2];
   // Natural overflow of the word index gives the wrap from the top word to 0
   assign widx_next = widx + 1'b1;
   assign mask      = ((8'd1 << size) - 8'd1) << off;
   assign crosses   = |mask[7:4];
   assign st_wide   = {{DATA_W{1'b0}}, wdata_q} << {off, 3'b000};
   assign w1        = crosses ? word1_q : 24'd0;

   always_comb begin
      size = 4'd4;
      case (funct3_q[1:0])
         2'b00:   size = 4'd1;
         2'b01:   size = 4'd2;
         default: size = 4'd4;
      endcase
   end

   // Only the low three bytes of the second word can ever reach the result
   always_comb begin
      ld_word = word0_q;
      case (off)
         2'd0: ld_word = word0_q;
         2'd1: ld_word = {w1[7:0],  word0_q[31:8]};
         2'd2: ld_word = {w1[15:0], word0_q[31:16]};
         2'd3: ld_word = {w1[23:0], word0_q[31:24]};
         default: ld_word = word0_q;
      endcase
   end

   always_comb begin
      ld_ext = '0;
      case (funct3_q)
         3'b000:  ld_ext = {{24{ld_word[7]}}, ld_word[7:0]};
         3'b001:  ld_ext = {{16{ld_word[15]}}, ld_word[15:0]};
         3'b010:  ld_ext = ld_word;
         3'b100:  ld_ext = {24'd0, ld_word[7:0]};
         3'b101:  ld_ext = {16'd0, ld_word[15:0]};
         default: ld_ext = '0;
      endcase
   end

   always_comb begin
      state_d   = state_q;
      store_d   = store_q;
      err_d     = err_q;
      addr_d    = addr_q;
      wdata_d   = wdata_q;
      funct3_d  = funct3_q;
      word0_d   = word0_q;
      word1_d   = word1_q;
      req_ready = 1'b0;
      mem_addr  = '0;
      mem_re    = 1'b0;
      mem_be    = 4'b0000;
      mem_wdata = '0;
      rsp_valid = 1'b0;
      rsp_rdata = '0;
      rsp_err   = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            req_ready = 1'b1;
            if (req_valid) begin
               store_d  = req_store;
               addr_d   = req_addr;
               wdata_d  = req_wdata;
               funct3_d = req_funct3;
               err_d    = !req_legal;
               state_d  = req_legal ? S_FIRST : S_RESP;
            end
         end
         S_FIRST: begin
            mem_addr  = {widx, 2'b00};
            mem_re    = !store_q;
            mem_be    = store_q ? mask[3:0] : 4'b0000;
            mem_wdata = store_q ? st_wide[DATA_W-1:0] : '0;
            word0_d   = mem_rdata;
            state_d   = crosses ? S_SECOND : S_RESP;
         end
         S_SECOND: begin
            mem_addr  = {widx_next, 2'b00};
            mem_re    = !store_q;
            mem_be    = store_q ? mask[7:4] : 4'b0000;
            mem_wdata = store_q ? st_wide[2*DATA_W-1:DATA_W] : '0;
            word1_d   = mem_rdata[23:0];
            state_d   = S_RESP;
         end
         S_RESP: begin
            rsp_valid = 1'b1;
            rsp_err   = err_q;
            rsp_rdata = (store_q || err_q) ? '0 : ld_ext;
            state_d   = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= S_IDLE;
         store_q  <= 1'b0;
         err_q    <= 1'b0;
         addr_q   <= '0;
         wdata_q  <= '0;
         funct3_q <= 3'b000;
         word0_q  <= '0;
         word1_q  <= '0;
      end else begin
         state_q  <= state_d;
         store_q  <= store_d;
         err_q    <= err_d;
         addr_q   <= addr_d;
         wdata_q  <= wdata_d;
         funct3_q <= funct3_d;
         word0_q  <= word0_d;
         word1_q  <= word1_d;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_lsu_access_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_lsu_access_sequencer: bench for lsu_access_sequencer with a byte-level |
// | memory reference model.  Rev 1.0                                         |
// +--------------------------------------------------------------------------+
module tb_lsu_access_sequencer;
   localparam int AW = 9;

   logic        clk = 1'b0;
   logic        reset;
   logic        req_valid;
   logic        req_ready;
   logic        req_store;
   logic [8:0]  req_addr;
   logic [31:0] req_wdata;
   logic [2:0]  req_funct3;
   logic [8:0]  mem_addr;
   logic        mem_re;
   logic [3:0]  mem_be;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata;
   logic        rsp_valid;
   logic [31:0] rsp_rdata;
   logic        rsp_err;

   lsu_access_sequencer #(.DM_ADDRESS(AW), .DATA_W(32)) dut (
      .clk        (clk),
      .reset      (reset),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_store  (req_store),
      .req_addr   (req_addr),
      .req_wdata  (req_wdata),
      .req_funct3 (req_funct3),
      .mem_addr   (mem_addr),
      .mem_re     (mem_re),
      .mem_be     (mem_be),
      .mem_wdata  (mem_wdata),
      .mem_rdata  (mem_rdata),
      .rsp_valid  (rsp_valid),
      .rsp_rdata  (rsp_rdata),
      .rsp_err    (rsp_err)
   );

   always #5 clk = ~clk;

   // Word memory seen by the DUT, and the byte-level model of what it should hold
   logic [31:0] dm [128];
   logic [7:0]  ref_mem [512];
   assign mem_rdata = dm[mem_addr[8:2]];

   int checks   = 0;
   int failures = 0;

   int          o_lat, o_n, o_mis;
   logic [8:0]  o_a  [2];
   logic [3:0]  o_be [2];
   logic [31:0] o_wd [2];
   logic [31:0] o_rd;
   logic        o_err, o_ready_resp;

   typedef struct {
      logic        st;
      logic [8:0]  a;
      logic [31:0] wd;
      logic [2:0]  f3;
      logic [8:0]  pa0;
      logic [31:0] pv0;
      logic [8:0]  pa1;
      logic [31:0] pv1;
      logic [31:0] erd;
      logic        eerr;
      int          elat;
      logic [8:0]  ea0;
      logic [3:0]  ebe0;
      logic [31:0] ewd0;
      logic [8:0]  ea1;
      logic [3:0]  ebe1;
      logic [31:0] ewd1;
   } vec_t;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: actual=%h expected=%h", name, act, exp);
      end
   endtask

   task automatic set_word(input logic [8:0] a, input logic [31:0] v);
      dm[a[8:2]] = v;
      for (int b = 0; b < 4; b++) ref_mem[int'({a[8:2], 2'b00}) + b] = v[8*b +: 8];
   endtask

   function automatic int f_size(input logic [2:0] f3);
      if (f3[1:0] == 2'b00) return 1;
      if (f3[1:0] == 2'b01) return 2;
      return 4;
   endfunction

   function automatic logic f_legal(input logic st, input logic [2:0] f3);
      if (st) return (f3 <= 3'd2);
      return (f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd2 || f3 == 3'd4 || f3 == 3'd5);
   endfunction

   function automatic logic f_cross(input logic [8:0] a, input logic [2:0] f3);
      return (int'(a[1:0]) + f_size(f3)) > 4;
   endfunction

   function automatic logic [31:0] f_load(input logic [8:0] a, input logic [2:0] f3);
      int sz;
      logic [31:0] v;
      sz = f_size(f3);
      v  = 32'd0;
      for (int i = 0; i < sz; i++) v[8*i +: 8] = ref_mem[(int'(a) + i) % 512];
      if (sz == 1 && !f3[2] && v[7])  v[31:8]  = 24'hFFFFFF;
      if (sz == 2 && !f3[2] && v[15]) v[31:16] = 16'hFFFF;
      return v;
   endfunction

   task automatic model_store(input logic [8:0] a, input logic [31:0] wd, input logic [2:0] f3);
      for (int i = 0; i < f_size(f3); i++) ref_mem[(int'(a) + i) % 512] = wd[8*i +: 8];
   endtask

   function automatic int mem_diffs();
      int n;
      n = 0;
      for (int w = 0; w < 128; w++)
         if (dm[w] !== {ref_mem[4*w+3], ref_mem[4*w+2], ref_mem[4*w+1], ref_mem[4*w]}) n++;
      return n;
   endfunction

   function automatic logic [31:0] bmask(input logic [3:0] be);
      return {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
   endfunction

   // Issues one request, scrambles the request bus after acceptance, and records
   // every memory strobe until the response pulse (or a cycle budget expires).
   task automatic run_req(input logic st, input logic [8:0] a, input logic [31:0] wd,
                          input logic [2:0] f3);
      int guard;
      o_n = 0; o_mis = 0;
      for (int k = 0; k < 2; k++) begin o_a[k] = '0; o_be[k] = '0; o_wd[k] = '0; end
      @(negedge clk);
      req_valid = 1'b1; req_store = st; req_addr = a; req_wdata = wd; req_funct3 = f3;
      guard = 0;
      while (!req_ready && guard < 10) begin @(negedge clk); guard++; end
      @(negedge clk);
      req_valid  = 1'b0;
      req_store  = 1'($urandom_range(0, 1));
      req_addr   = 9'($urandom_range(0, 511));
      req_wdata  = $urandom;
      req_funct3 = 3'($urandom_range(0, 7));
      o_lat = 1;
      while (!rsp_valid && o_lat < 8) begin
         if (mem_re || mem_be != 4'b0000) begin
            if (o_n < 2) begin o_a[o_n] = mem_addr; o_be[o_n] = mem_be; o_wd[o_n] = mem_wdata; end
            if (mem_addr[1:0] != 2'b00) o_mis++;
            o_n++;
            for (int b = 0; b < 4; b++)
               if (mem_be[b]) dm[mem_addr[8:2]][8*b +: 8] = mem_wdata[8*b +: 8];
         end
         @(negedge clk);
         o_lat++;
      end
      o_rd = rsp_rdata; o_err = rsp_err; o_ready_resp = req_ready;
      @(negedge clk);
      chk("rsp_single_pulse", {31'd0, rsp_valid}, 32'd0);
   endtask

   vec_t vec [8];

   initial begin
      logic        st;
      logic [8:0]  a;
      logic [31:0] wd, erd;
      logic [2:0]  f3;
      int          elat, en, pulses;

      vec[0] = '{1'b0, 9'h010, 32'h0, 3'b010, 9'h010, 32'hDEADBEEF, 9'h010, 32'hDEADBEEF,
                 32'hDEADBEEF, 1'b0, 2, 9'h010, 4'h0, 32'h0, 9'h0, 4'h0, 32'h0};
      vec[1] = '{1'b0, 9'h013, 32'h0, 3'b000, 9'h010, 32'h80FFFFFF, 9'h010, 32'h80FFFFFF,
                 32'hFFFFFF80, 1'b0, 2, 9'h010, 4'h0, 32'h0, 9'h0, 4'h0, 32'h0};
      vec[2] = '{1'b0, 9'h013, 32'h0, 3'b100, 9'h010, 32'h80FFFFFF, 9'h010, 32'h80FFFFFF,
                 32'h00000080, 1'b0, 2, 9'h010, 4'h0, 32'h0, 9'h0, 4'h0, 32'h0};
      vec[3] = '{1'b0, 9'h007, 32'h0, 3'b001, 9'h004, 32'hAB000000, 9'h008, 32'h000000CD,
                 32'hFFFFCDAB, 1'b0, 3, 9'h004, 4'h0, 32'h0, 9'h008, 4'h0, 32'h0};
      vec[4] = '{1'b1, 9'h00E, 32'h11223344, 3'b010, 9'h00C, 32'h0, 9'h010, 32'h0,
                 32'h0, 1'b0, 3, 9'h00C, 4'hC, 32'h33440000, 9'h010, 4'h3, 32'h00001122};
      vec[5] = '{1'b1, 9'h1FF, 32'h0000A55A, 3'b001, 9'h1FC, 32'h0, 9'h000, 32'h0,
                 32'h0, 1'b0, 3, 9'h1FC, 4'h8, 32'h5A000000, 9'h000, 4'h1, 32'h000000A5};
      vec[6] = '{1'b0, 9'h020, 32'h0, 3'b011, 9'h020, 32'h12345678, 9'h020, 32'h12345678,
                 32'h0, 1'b1, 1, 9'h0, 4'h0, 32'h0, 9'h0, 4'h0, 32'h0};
      vec[7] = '{1'b1, 9'h024, 32'hCAFEF00D, 3'b100, 9'h024, 32'h0, 9'h024, 32'h0,
                 32'h0, 1'b1, 1, 9'h0, 4'h0, 32'h0, 9'h0, 4'h0, 32'h0};

      reset = 1'b1; req_valid = 1'b0; req_store = 1'b0; req_addr = '0;
      req_wdata = '0; req_funct3 = '0;
      for (int w = 0; w < 128; w++) set_word(9'(w * 4), $urandom);
      repeat (3) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      chk("reset_req_ready", {31'd0, req_ready}, 32'd1);
      chk("reset_strobes", {27'd0, mem_re, mem_be}, 32'd0);
      chk("reset_mem_addr", {23'd0, mem_addr}, 32'd0);
      chk("reset_mem_wdata", mem_wdata, 32'd0);
      chk("reset_rsp", {30'd0, rsp_valid, rsp_err}, 32'd0);
      chk("reset_rsp_rdata", rsp_rdata, 32'd0);

      for (int k = 0; k < 8; k++) begin
         set_word(vec[k].pa0, vec[k].pv0);
         set_word(vec[k].pa1, vec[k].pv1);
         run_req(vec[k].st, vec[k].a, vec[k].wd, vec[k].f3);
         chk($sformatf("v%0d_latency", k), o_lat, vec[k].elat);
         chk($sformatf("v%0d_rdata", k), o_rd, vec[k].erd);
         chk($sformatf("v%0d_err", k), {31'd0, o_err}, {31'd0, vec[k].eerr});
         chk($sformatf("v%0d_accesses", k), o_n, vec[k].elat - 1);
         chk($sformatf("v%0d_ready_in_resp", k), {31'd0, o_ready_resp}, 32'd0);
         if (vec[k].elat >= 2) begin
            chk($sformatf("v%0d_addr0", k), {23'd0, o_a[0]}, {23'd0, vec[k].ea0});
            chk($sformatf("v%0d_be0", k), {28'd0, o_be[0]}, {28'd0, vec[k].ebe0});
            if (vec[k].st) chk($sformatf("v%0d_wdata0", k), o_wd[0] & bmask(vec[k].ebe0), vec[k].ewd0);
            else           chk($sformatf("v%0d_wdata0", k), o_wd[0], 32'd0);
         end
         if (vec[k].elat == 3) begin
            chk($sformatf("v%0d_addr1", k), {23'd0, o_a[1]}, {23'd0, vec[k].ea1});
            chk($sformatf("v%0d_be1", k), {28'd0, o_be[1]}, {28'd0, vec[k].ebe1});
            if (vec[k].st) chk($sformatf("v%0d_wdata1", k), o_wd[1] & bmask(vec[k].ebe1), vec[k].ewd1);
            else           chk($sformatf("v%0d_wdata1", k), o_wd[1], 32'd0);
         end
         if (vec[k].st && f_legal(vec[k].st, vec[k].f3)) begin
            model_store(vec[k].a, vec[k].wd, vec[k].f3);
            chk($sformatf("v%0d_mem_image", k), mem_diffs(), 32'd0);
         end
      end

      for (int t = 0; t < 300; t++) begin
         st = 1'($urandom_range(0, 1));
         a  = 9'($urandom_range(0, 511));
         wd = $urandom;
         f3 = 3'($urandom_range(0, 7));
         if (!f_legal(st, f3)) begin elat = 1; en = 0; end
         else if (f_cross(a, f3)) begin elat = 3; en = 2; end
         else begin elat = 2; en = 1; end
         erd = (st || !f_legal(st, f3)) ? 32'd0 : f_load(a, f3);
         run_req(st, a, wd, f3);
         chk("rand_latency", o_lat, elat);
         chk("rand_rdata", o_rd, erd);
         chk("rand_err", {31'd0, o_err}, {31'd0, !f_legal(st, f3)});
         chk("rand_accesses", o_n, en);
         chk("rand_addr_aligned", o_mis, 0);
         if (st && f_legal(st, f3)) begin
            model_store(a, wd, f3);
            chk("rand_mem_image", mem_diffs(), 32'd0);
         end
      end

      // A request held high is taken again in the IDLE cycle following RESP
      set_word(9'h040, 32'h01020304);
      @(negedge clk);
      req_valid = 1'b1; req_store = 1'b0; req_addr = 9'h040; req_funct3 = 3'b010;
      pulses = 0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         if (rsp_valid) begin
            pulses++;
            chk("held_rdata", rsp_rdata, 32'h01020304);
         end
      end
      req_valid = 1'b0;
      chk("held_pulses", pulses, 2);
      repeat (3) @(negedge clk);

      // Reset during SECOND of a crossing load
      set_word(9'h004, 32'h11111111);
      set_word(9'h008, 32'h22222222);
      chk("rst_seq_idle", {31'd0, req_ready}, 32'd1);
      req_valid = 1'b1; req_store = 1'b0; req_addr = 9'h005; req_funct3 = 3'b010;
      @(negedge clk);
      req_valid = 1'b0;
      @(negedge clk);
      chk("rst_seq_second_re", {31'd0, mem_re}, 32'd1);
      chk("rst_seq_second_addr", {23'd0, mem_addr}, 32'h008);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      chk("rst_seq_ready", {31'd0, req_ready}, 32'd1);
      chk("rst_seq_strobes", {27'd0, mem_re, mem_be}, 32'd0);
      pulses = 0;
      for (int i = 0; i < 4; i++) begin
         if (rsp_valid) pulses++;
         @(negedge clk);
      end
      chk("rst_seq_no_rsp", pulses, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/lsu_access_sequencer.md
Name: lsu_access_sequencer

Overview:
- MEM-stage load/store sequencer; sits directly upstream of the data memory and is fed by the EX/MEM pipeline register.
- Accepts one load/store request (byte address, store data, funct3) and issues one or two word-aligned memory accesses with byte enables.
- Splits misaligned accesses that cross a word boundary; returns the merged, sign/zero-extended load result with a valid pulse.
- Pipeline stalls while req_ready is low.

Parameters:
- DM_ADDRESS, 9: byte-address width presented to data memory.
- DATA_W, 32: data width; only 32 is supported.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  high only in IDLE; request accepted when req_valid & req_ready.
- req_store  in  1  1=store, 0=load.
- req_addr  in  DM_ADDRESS  byte address (ALU result LSBs).
- req_wdata  in  DATA_W  store data (rs2).
- req_funct3  in  3  instr[14:12].
- mem_addr  out  DM_ADDRESS  word-aligned byte address; bits [1:0] always 0.
- mem_re  out  1  read strobe.
- mem_be  out  4  byte write enables; 0 for loads.
- mem_wdata  out  DATA_W  lane-shifted store data.
- mem_rdata  in  DATA_W  combinational read data for mem_addr.
- rsp_valid  out  1  one-cycle completion pulse (loads and stores).
- rsp_rdata  out  DATA_W  extended load result; 0 for stores/errors.
- rsp_err  out  1  illegal funct3; valid with rsp_valid.

Behaviour:
- Reset: state=IDLE; req_ready=1; mem_re=0, mem_be=0, mem_addr=0, mem_wdata=0; rsp_valid=0, rsp_rdata=0, rsp_err=0; internal registers cleared.
- Size from funct3:
  - Loads: 000 LB=1, 001 LH=2, 010 LW=4, 100 LBU=1, 101 LHU=2; others illegal.
  - Stores: 000 SB, 001 SH, 010 SW; others illegal.
- On accept: latch store flag, addr, wdata, funct3. Compute off=addr[1:0] and mask=(1<<size)-1 over 8 bits shifted left by off. crosses = |mask[7:4].
- FSM states: IDLE, FIRST, SECOND, RESP.
  - IDLE -> FIRST on accept of a legal request.
  - IDLE -> RESP on accept of an illegal request; no memory activity.
  - FIRST: mem_addr={addr[DM_ADDRESS-1:2],2'b00}; loads mem_re=1, stores mem_be=mask[3:0]. Capture mem_rdata into word0. Next state SECOND if crosses, else RESP.
  - SECOND: mem_addr=next word, index addr[DM_ADDRESS-1:2]+1 modulo 2^(DM_ADDRESS-2), so the top word wraps to 0. Loads mem_re=1, stores mem_be=mask[7:4]. Capture word1. -> RESP.
  - RESP: rsp_valid=1 for exactly one cycle; -> IDLE. req_ready=0 in RESP; a request held high is accepted in the following IDLE cycle.
- Latency from accept at cycle T:
  - Non-crossing: FIRST at T+1, rsp_valid at T+2.
  - Crossing: SECOND at T+2, rsp_valid at T+3.
  - Illegal: rsp_valid at T+1.
- Store data: 64-bit {32'b0,wdata} << 8*off. Low half drives mem_wdata in FIRST, high half in SECOND. Bytes with be=0 are don't-care.
- Load data: ({word1,word0} >> 8*off)[31:0], then sign-extend (LB/LH), zero-extend (LBU/LHU), or pass through (LW). word1 is treated as 0 when not crossing.
- mem_re, mem_be and mem_wdata are 0 outside FIRST/SECOND. rsp_rdata/rsp_err hold 0 outside RESP.
- Reset mid-operation (any state): next cycle IDLE, no further strobes, no rsp_valid. A first-half store already written stays written; this is accepted behaviour.
- req_* changes while req_ready=0 are ignored; the latched copy is used.

Test Plan:
- Aligned LW addr=0x010, memory word 0x010=0xDEADBEEF -> one read at 0x010; rsp_valid at T+2; rsp_rdata=0xDEADBEEF, rsp_err=0.
- LB addr=0x013, word=0x80FFFFFF -> rsp_rdata=0xFFFFFF80. Same address with LBU -> 0x00000080.
- Crossing LH addr=0x007, word 0x004=0xAB000000, word 0x008=0x000000CD -> reads at 0x004 then 0x008; rsp_rdata=0xFFFFCDAB at T+3.
- Crossing SW addr=0x00E, wdata=0x11223344 -> FIRST mem_addr=0x00C, be=1100, wdata[31:16]=0x3344. SECOND mem_addr=0x010, be=0011, wdata[15:0]=0x1122. rsp_valid at T+3.
- Wrap: SH addr=0x1FF (DM_ADDRESS=9) -> be=1000 at 0x1FC, then be=0001 at 0x000.
- Illegal funct3=011 load -> no mem_re/mem_be; rsp_valid at T+1 with rsp_err=1, rsp_rdata=0. Then reset asserted during SECOND of a crossing load -> next cycle IDLE, req_ready=1, no rsp_valid.
